// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and idle line level.
// Defining UART_TX_PARITY_EN adds the PARITY state and widens the encoding to 3 bits.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;
`endif

    localparam int   CLKS_PER_BIT_DEFAULT = 16;
    localparam logic LINE_IDLE            = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1, flags the last clock with bit_end, and clears on request.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
    parameter int CLK_CNT_WIDTH = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam logic [CLK_CNT_WIDTH-1:0] CNT_LAST = CLK_CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CLK_CNT_WIDTH-1:0] clk_cnt;

    assign bit_end = (clk_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt <= '0;
        end else if (clr || bit_end) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CLK_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, 8N1 frame out on tx, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH       = 8,
    parameter int DATA_LENGTH_WIDTH = $clog2(DATA_LENGTH),
    parameter int CLKS_PER_BIT      = CLKS_PER_BIT_DEFAULT,
    parameter int CLK_CNT_WIDTH     = $clog2(CLKS_PER_BIT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam logic [DATA_LENGTH_WIDTH-1:0] LAST_BIT = DATA_LENGTH_WIDTH'(DATA_LENGTH - 1);

    uart_state_t                  state, state_nx;
    logic [DATA_LENGTH-1:0]       shift, shift_nx;
    logic [DATA_LENGTH_WIDTH-1:0] bit_cnt, bit_cnt_nx;
    logic                         tx_nx;
    logic                         done_nx;
    logic                         bit_end;
    logic                         timer_clr;
`ifdef UART_TX_PARITY_EN
    logic                         par, par_nx;
`endif

    // Counter restarts on every state change so each state starts a fresh bit period.
    assign timer_clr = (state == IDLE) || (state_nx != state);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CLK_CNT_WIDTH(CLK_CNT_WIDTH)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .bit_end(bit_end)
    );

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        tx_nx      = tx;
        done_nx    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nx     = par;
`endif
        case (state)
            IDLE: begin
                tx_nx = LINE_IDLE;
                if (tx_valid && tx_ready) begin
                    state_nx   = START;
                    shift_nx   = tx_data;
                    bit_cnt_nx = '0;
                    tx_nx      = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nx     = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    tx_nx    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nx = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
                        state_nx   = PARITY;
                        tx_nx      = par;
`else
                        state_nx   = STOP;
                        tx_nx      = LINE_IDLE;
`endif
                    end else begin
                        bit_cnt_nx = bit_cnt + DATA_LENGTH_WIDTH'(1);
                        tx_nx      = shift_nx[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    tx_nx    = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                tx_nx = LINE_IDLE;
                if (bit_end) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = LINE_IDLE;
            end
        endcase
    end

    // All outputs come straight from flops so the line never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            tx       <= LINE_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            shift    <= shift_nx;
            bit_cnt  <= bit_cnt_nx;
            tx       <= tx_nx;
            tx_ready <= (state_nx == IDLE);
            tx_busy  <= (state_nx != IDLE);
            tx_done  <= done_nx;
`ifdef UART_TX_PARITY_EN
            par      <= par_nx;
`endif
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that produces the 8N1 frame consumed by the team's UART receiver on the `rx` line. It sits directly upstream of the receiver.
- Accepts a parallel byte through a valid/ready handshake, then shifts it out LSB first:
  - start bit 0,
  - DATA_LENGTH data bits,
  - stop bit 1.
- Each bit is held for CLKS_PER_BIT clocks. The default of 16 matches the receiver's 16-clock bit period.
- Used both as the board TX path and as the loopback stimulus driver for receiver tests.

Parameters:
- DATA_LENGTH, 8, number of data bits per frame.
- DATA_LENGTH_WIDTH, $clog2(DATA_LENGTH), width of the bit index counter.
- CLKS_PER_BIT, 16, clocks per serial bit. Must be ≥ 2.
- CLK_CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the bit-period counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- tx_data  input  DATA_LENGTH  byte to send. Sampled only on handshake.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte. High only in IDLE.
- tx  output  1  serial line. Registered. Idles high.
- tx_busy  output  1  high while a frame is in progress (START..STOP).
- tx_done  output  1  one-clock pulse when a frame's stop bit completes.

Behaviour:
- Reset values (while rst=0, asynchronously):
  - state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0,
  - shift register=0, counters=0.
- States: IDLE, START, DATA, STOP (2-bit encoding, from the package).
- Handshake:
  - Transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register.
  - Next state is START and tx goes 0 on that same edge.
  - tx_data may change freely after the transfer edge.
- Bit timing:
  - clk_cnt counts 0..CLKS_PER_BIT-1 in START, DATA and STOP.
  - "bit_end" = (clk_cnt == CLKS_PER_BIT-1).
  - clk_cnt clears on every state change and holds 0 in IDLE.
- START: tx=0. On bit_end, go to DATA and drive tx = shift[0].
- DATA:
  - tx = current LSB.
  - On bit_end: shift right, bit_cnt+1.
  - After bit_cnt reaches DATA_LENGTH-1 and bit_end, go to STOP with tx=1.
- STOP:
  - tx=1.
  - On bit_end: go to IDLE, pulse tx_done for exactly the next clock, assert tx_ready.
- Latency and frame length:
  - From the transfer edge, tx is low for exactly CLKS_PER_BIT clocks.
  - Full frame = (DATA_LENGTH+2)*CLKS_PER_BIT clocks.
  - tx_done is high in the first IDLE cycle.
- Back-to-back:
  - If tx_valid is held high, the next transfer occurs on the first IDLE cycle.
  - This gives exactly 1 idle-high clock between the stop bit and the next start bit.
  - No transfer occurs on the STOP→IDLE edge itself.
- Busy/ready: tx_busy = (state != IDLE); tx_ready = (state == IDLE). Both are registered and are never high together.
- Boundary conditions:
  - tx_valid asserted mid-frame is ignored. No queuing.
  - A tx_valid pulse shorter than one IDLE cycle is lost only if it falls outside IDLE.
  - Reset asserted mid-frame aborts immediately with tx=1. No partial byte is resumed.
- tx never glitches: it is driven only from a flop.

Optional Feature:
- UART_TX_PARITY_EN:
  - When defined, a PARITY state is inserted between DATA and STOP.
  - PARITY drives the even-parity bit (XOR of the latched byte) for CLKS_PER_BIT clocks.
  - The state encoding widens to 3 bits.
  - Frame length = (DATA_LENGTH+3)*CLKS_PER_BIT.
- When undefined: no PARITY state, 2-bit encoding, 8N1 frame exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - state localparams (IDLE, START, DATA, STOP, PARITY),
  - the default CLKS_PER_BIT=16,
  - the idle line level constant.
- The receiver is migrated to the same package.
- One sub-module, uart_bit_timer:
  - a clk_cnt counter with clear input and bit_end output,
  - parameterised by CLKS_PER_BIT,
  - reused later by the receiver.

Test Plan:
- Reset idle: rst=0 for 3 clocks then 1, tx_valid=0 → tx=1, tx_ready=1, tx_busy=0, tx_done=0 held for 50 clocks.
- Single byte 0x55, CLKS_PER_BIT=16:
  - line shows 0 for 16 clocks, then 1,0,1,0,1,0,1,0 (16 clocks each), then 1 for 16,
  - tx_done pulses once at clock 160 after transfer,
  - tx_busy high for 160 clocks.
- Back-to-back 0xA3 then 0x3C with tx_valid held:
  - second start bit begins exactly 1 clock after the first stop bit ends,
  - decoded bytes are 0xA3 and 0x3C.
- Mid-frame valid: assert tx_valid with 0xFF during the DATA bits of 0x00 → 0xFF is not accepted until tx_ready. The first frame's bits stay all 0.
- Reset mid-frame: rst=0 during bit 3 of 0x0F → tx=1, state IDLE, tx_ready=1 within the same cycle, no tx_done.
- Loopback into the receiver, bytes 0x00, 0xFF, 0x81, 0x7E:
  - receiver data matches each byte,
  - one receiver done per frame.
  - With UART_TX_PARITY_EN: parity bit is 0 for 0x81 and 1 for 0x01.
